link_arbiter: RTL and testbench
===============================

Name: link_arbiter

Overview:
- Round-robin arbiter that shares one slave-side req/ack/data link between NUM_REQ master FSMs, each of which speaks the four-phase handshake.
- Sits between the master FSMs and the single slave FSM inside the link top level.
- Selects one requester, forwards its data, relays the acknowledge back to it, and releases the link only after the full four-phase return-to-zero.
- Aborts a transfer that the slave does not acknowledge within a timeout.

Parameters:
- NUM_REQ, 4, number of master ports (2..8).
- DATA_W, 8, data width per link.
- ACK_TIMEOUT, 16, cycles in REQ without s_ack before abort (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- m_req  input  NUM_REQ  per-master request, bit i = master i.
- m_data  input  NUM_REQ*DATA_W  master data, master i at bits [i*DATA_W +: DATA_W].
- m_ack  output  NUM_REQ  per-master acknowledge; at most one bit set.
- s_req  output  1  request to slave.
- s_data  output  DATA_W  data to slave, held stable while s_req=1.
- s_ack  input  1  acknowledge from slave.
- grant_id  output  clog2(NUM_REQ)  index of the current or last granted master.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all outputs registered and 0 after the rst edge, including m_ack, s_req, s_data, grant_id, busy and err.
  - The round-robin pointer last resets to NUM_REQ-1, so master 0 has first priority.
  - The timeout counter resets to 0.
  - rst asserted mid-transfer aborts immediately: no err pulse, s_req and m_ack drop the next edge.
- IDLE, arbitration: on a cycle with any m_req bit set:
  - The winner is the first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Register grant_id=winner and s_data=m_data[winner], then go to REQ.
  - s_req=1 from the next cycle, so grant latency is 1 cycle from m_req to s_req.
  - No m_req set: stay in IDLE.
- REQ: s_req=1 and s_data is held.
  - s_ack=1: set m_ack[grant_id]=1, go to HOLD.
  - Otherwise the counter increments each cycle.
  - Counter reaching ACK_TIMEOUT-1 with s_ack=0: s_req=0, err=1 for one cycle, last=grant_id, go to IDLE. m_ack is never asserted for that master.
- HOLD: m_ack[grant_id]=1 and s_req=1.
  - m_req[grant_id]=0: s_req=0 next cycle, go to DROP.
  - m_ack stays 1 until the slave releases.
- DROP: s_req=0.
  - s_ack=0: m_ack[grant_id]=0, last=grant_id, go to IDLE.
  - Arbitration is not evaluated in the same cycle, so there is at least 1 idle cycle between grants.
- Simultaneous requests: the loser's m_req is ignored until IDLE. Requests are level-sensitive, so no request is lost.
- A master dropping m_req while in REQ (protocol violation): the transfer still completes to the slave, and HOLD exits on its first cycle.
- s_ack already high on entry to REQ: treated as an acknowledge in the first REQ cycle.
- Changes on m_data after the grant have no effect on s_data.
- The pointer advances only on transfer completion or abort, giving strict rotation among persistent requesters.
- grant_id holds its value through IDLE until the next arbitration.

Test Plan:
- Reset then a single request: rst high 2 cycles; m_req=4'b0100, m_data[23:16]=8'hA5; slave acks 2 cycles after s_req.
  - Required: s_req rises 1 cycle after m_req with s_data=8'hA5 and grant_id=2.
  - Required: m_ack[2] rises the cycle after s_ack.
  - Required: after master release, s_req falls, then m_ack[2] falls after s_ack falls, and busy returns to 0.
- All requesting persistently: m_req=4'b1111, each master restarting after its ack falls.
  - Required: grant order 0,1,2,3,0,1.
  - Required: m_ack is never more than one-hot.
- Fairness after a single grant: the first grant goes to master 1 (m_req=4'b0010); then m_req=4'b0011 simultaneously. Required: master 0 is not starved; next order is 0 then 1.
- Slave timeout: m_req=4'b0001 and s_ack tied to 0.
  - Required: s_req high for exactly ACK_TIMEOUT=16 cycles.
  - Required: err pulses 1 cycle, m_ack stays 0, and the next request from master 1 is granted first.
- Mid-transfer reset: rst asserted during HOLD. Required: the next cycle has s_req=0, m_ack=0, busy=0 and err=0, and master 0 has priority again.
- Data stability: m_data of the granted master changes every cycle during REQ/HOLD. Required: s_data constant at the value captured at grant.

Source files
------------

// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack/data slave link among NUM_REQ masters.
// A transfer the slave does not acknowledge within ACK_TIMEOUT cycles is aborted with an err pulse.
module link_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         m_req,
    input  logic [NUM_REQ*DATA_W-1:0]  m_data,
    output logic [NUM_REQ-1:0]         m_ack,
    output logic                       s_req,
    output logic [DATA_W-1:0]          s_data,
    input  logic                       s_ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [ID_W-1:0]    LAST_RST = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [ID_W-1:0]    last_r, last_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [NUM_REQ-1:0] m_ack_r, m_ack_nxt_s;
    logic               s_req_r, s_req_nxt_s;
    logic [DATA_W-1:0]  s_data_r, s_data_nxt_s;
    logic [ID_W-1:0]    grant_id_r, grant_id_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               err_r, err_nxt_s;
    logic               any_req_s;
    logic               timeout_s;
    logic [ID_W-1:0]    winner_s;
    logic [NUM_REQ-1:0] grant_onehot_s;

    // First requester found scanning last+1, last+2, ... modulo NUM_REQ; scanning
    // backwards lets the nearest position overwrite the farther ones.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pos;
        idx = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = ID_W'((int'(last) + k) % NUM_REQ);
            idx = req[pos] ? pos : idx;
        end
        return idx;
    endfunction

    assign any_req_s      = |m_req;
    assign timeout_s      = (cnt_r == CNT_LAST);
    assign winner_s       = rr_pick(m_req, last_r);
    assign grant_onehot_s = ONE_LSB << grant_id_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode of the four-phase handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_nxt_s = ST_REQ;
                else           state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (s_ack)          state_nxt_s = ST_HOLD;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_REQ;
            end
            ST_HOLD: begin
                if (!m_req[grant_id_r]) state_nxt_s = ST_DROP;
                else                    state_nxt_s = ST_HOLD;
            end
            ST_DROP: begin
                if (!s_ack) state_nxt_s = ST_IDLE;
                else        state_nxt_s = ST_DROP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and timeout counter
    always_comb begin
        grant_id_nxt_s = grant_id_r;
        s_data_nxt_s   = s_data_r;
        last_nxt_s     = last_r;
        cnt_nxt_s      = {CNT_W{1'b0}};
        m_ack_nxt_s    = {NUM_REQ{1'b0}};
        s_req_nxt_s    = 1'b0;
        err_nxt_s      = 1'b0;
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_id_nxt_s = winner_s;
                    s_data_nxt_s   = m_data[winner_s*DATA_W +: DATA_W];
                    s_req_nxt_s    = 1'b1;
                end else begin
                    s_req_nxt_s    = 1'b0;
                end
            end
            ST_REQ: begin
                if (s_ack) begin
                    m_ack_nxt_s = grant_onehot_s;
                    s_req_nxt_s = 1'b1;
                end else if (timeout_s) begin
                    // The aborted master counts as served so rotation moves on.
                    err_nxt_s   = 1'b1;
                    last_nxt_s  = grant_id_r;
                end else begin
                    cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    s_req_nxt_s = 1'b1;
                end
            end
            ST_HOLD: begin
                m_ack_nxt_s = grant_onehot_s;
                if (m_req[grant_id_r]) s_req_nxt_s = 1'b1;
                else                   s_req_nxt_s = 1'b0;
            end
            ST_DROP: begin
                if (s_ack) begin
                    m_ack_nxt_s = grant_onehot_s;
                end else begin
                    last_nxt_s  = grant_id_r;
                end
            end
            default: begin
                m_ack_nxt_s = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // Output, pointer and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r     <= LAST_RST;
            cnt_r      <= {CNT_W{1'b0}};
            m_ack_r    <= {NUM_REQ{1'b0}};
            s_req_r    <= 1'b0;
            s_data_r   <= {DATA_W{1'b0}};
            grant_id_r <= {ID_W{1'b0}};
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            last_r     <= last_nxt_s;
            cnt_r      <= cnt_nxt_s;
            m_ack_r    <= m_ack_nxt_s;
            s_req_r    <= s_req_nxt_s;
            s_data_r   <= s_data_nxt_s;
            grant_id_r <= grant_id_nxt_s;
            busy_r     <= busy_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign m_ack    = m_ack_r;
    assign s_req    = s_req_r;
    assign s_data   = s_data_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule

// File: tb/tb_link_arbiter.sv
// Scoreboard bench for link_arbiter: directed tests queue the expected grants/aborts,
// a monitor pops and compares them whenever the DUT raises s_req or err.
module tb_link_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  m_req;
    logic [NR*DW-1:0] m_data;
    logic [NR-1:0]  m_ack;
    logic           s_req;
    logic [DW-1:0]  s_data;
    logic           s_ack;
    logic [1:0]     grant_id;
    logic           busy;
    logic           err;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            pend [NR] = '{default: 0};
    logic [DW-1:0] mdat [NR] = '{default: 8'h00};
    logic          hold     = 1'b0;
    logic          scramble = 1'b0;
    logic          slave_en = 1'b1;

    typedef struct packed {
        logic          is_abort;
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    link_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ACK_TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_data   (m_data),
        .m_ack    (m_ack),
        .s_req    (s_req),
        .s_data   (s_data),
        .s_ack    (s_ack),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_grant(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.is_abort = 1'b0;
        e.id       = 2'(id);
        e.data     = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_abort(input int id);
        exp_t e;
        e.is_abort = 1'b1;
        e.id       = 2'(id);
        e.data     = 8'h00;
        exp_q.push_back(e);
    endtask

    function automatic logic cond(input int sel);
        int total;
        total = 0;
        for (int i = 0; i < NR; i++) total += pend[i];
        case (sel)
            0: return (m_req != 4'b0000);
            1: return s_ack;
            2: return err;
            3: return (m_ack != 4'b0000);
            4: return (m_req == 4'b0000) && !busy && (total == 0);
            5: return !s_req;
            6: return !s_ack;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name);
        int n;
        n = 0;
        while (!cond(sel) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cond(sel)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_%s: condition not reached, required within 300 cycles", name);
        end
    endtask

    // Slave: acknowledges a few cycles after s_req, returns to zero once s_req drops.
    initial begin : slave_model
        int scnt;
        scnt  = 0;
        s_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !slave_en) begin
                s_ack = 1'b0;
                scnt  = 0;
            end else if (s_req && !s_ack) begin
                if (scnt >= 2) s_ack = 1'b1;
                else           scnt++;
            end else if (!s_req && s_ack) begin
                s_ack = 1'b0;
                scnt  = 0;
            end
        end
    end

    // Masters: raise a pending request, release on ack (unless held), give up on abort.
    initial begin : master_model
        m_req  = 4'b0000;
        m_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                m_req = 4'b0000;
                for (int i = 0; i < NR; i++) pend[i] = 0;
            end else begin
                for (int i = 0; i < NR; i++) begin
                    if (m_req[i] && err && int'(grant_id) == i) begin
                        m_req[i] = 1'b0;
                    end else if (m_req[i] && m_ack[i] && !hold) begin
                        m_req[i] = 1'b0;
                    end else if (!m_req[i] && !m_ack[i] && pend[i] > 0) begin
                        m_req[i]           = 1'b1;
                        m_data[i*DW +: DW] = mdat[i];
                        pend[i]            = pend[i] - 1;
                    end else if (m_req[i] && scramble && s_req && int'(grant_id) == i) begin
                        m_data[i*DW +: DW] = m_data[i*DW +: DW] + 8'h11;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every grant and abort, checks link invariants.
    initial begin : monitor
        exp_t          e;
        logic          prev_sreq;
        logic [DW-1:0] held;
        int            hi_cnt;
        prev_sreq = 1'b0;
        held      = 8'h00;
        hi_cnt    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sreq = 1'b0;
                hi_cnt    = 0;
            end else begin
                if (s_req && !prev_sreq) begin
                    check("grant_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("grant_kind", e.is_abort, 0);
                        check("grant_id", grant_id, e.id);
                        check("grant_s_data", s_data, e.data);
                    end
                    held   = s_data;
                    hi_cnt = 1;
                end else if (s_req) begin
                    check("s_data_stable", s_data, held);
                    hi_cnt++;
                end
                if (err) begin
                    check("abort_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("abort_kind", e.is_abort, 1);
                        check("abort_id", grant_id, e.id);
                    end
                    check("abort_s_req_cycles", hi_cnt, TMO);
                    check("abort_m_ack", m_ack, 0);
                end
                if (!s_req) hi_cnt = 0;
                check("m_ack_onehot", ($countones(m_ack) <= 1), 1);
                prev_sreq = s_req;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset values
        rst = 1'b1;
        @(negedge clk);
        check("rst_m_ack", m_ack, 0);
        check("rst_s_req", s_req, 0);
        check("rst_s_data", s_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request from master 2
        mdat[2] = 8'hA5;
        expect_grant(2, 8'hA5);
        pend[2] = 1;
        wait_for(0, "t1_m_req");
        check("t1_no_early_s_req", s_req, 0);
        @(negedge clk);
        check("t1_grant_latency", s_req, 1);
        check("t1_grant_id", grant_id, 2);
        check("t1_s_data", s_data, 8'hA5);
        check("t1_busy", busy, 1);
        wait_for(1, "t1_s_ack");
        check("t1_m_ack_before", m_ack, 4'b0000);
        @(negedge clk);
        check("t1_m_ack_rise", m_ack, 4'b0100);
        wait_for(5, "t1_s_req_fall");
        check("t1_m_ack_held", m_ack, 4'b0100);
        check("t1_busy_drop", busy, 1);
        wait_for(6, "t1_s_ack_fall");
        @(negedge clk);
        check("t1_m_ack_fall", m_ack, 4'b0000);
        check("t1_busy_idle", busy, 0);
        wait_for(4, "t1_done");

        // All masters persistent, from a fresh pointer
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdat[0] = 8'h10; mdat[1] = 8'h21; mdat[2] = 8'h32; mdat[3] = 8'h43;
        expect_grant(0, 8'h10); expect_grant(1, 8'h21); expect_grant(2, 8'h32);
        expect_grant(3, 8'h43); expect_grant(0, 8'h10); expect_grant(1, 8'h21);
        pend[0] = 2; pend[1] = 2; pend[2] = 1; pend[3] = 1;
        wait_for(4, "t2_done");

        // Fairness after a single grant to master 1
        mdat[0] = 8'h5A; mdat[1] = 8'hC3;
        expect_grant(1, 8'hC3);
        pend[1] = 1;
        wait_for(4, "t3_first");
        expect_grant(0, 8'h5A); expect_grant(1, 8'hC3);
        pend[0] = 1; pend[1] = 1;
        wait_for(4, "t3_done");

        // Slave timeout on master 0, then master 1 wins the next round
        slave_en = 1'b0;
        mdat[0]  = 8'h77;
        expect_grant(0, 8'h77);
        expect_abort(0);
        pend[0] = 1;
        wait_for(2, "t4_err");
        check("t4_m_ack_at_err", m_ack, 0);
        @(negedge clk);
        check("t4_err_one_cycle", err, 0);
        check("t4_m_ack_after", m_ack, 0);
        check("t4_busy_after", busy, 0);
        wait_for(4, "t4_quiet");
        slave_en = 1'b1;
        mdat[0] = 8'h66; mdat[1] = 8'h99;
        expect_grant(1, 8'h99); expect_grant(0, 8'h66);
        pend[0] = 1; pend[1] = 1;
        wait_for(4, "t4_done");

        // Reset during HOLD restores master 0 priority
        mdat[1] = 8'hB1;
        expect_grant(1, 8'hB1);
        pend[1] = 1;
        wait_for(4, "t5_pre");
        hold    = 1'b1;
        mdat[2] = 8'hE2;
        expect_grant(2, 8'hE2);
        pend[2] = 1;
        wait_for(3, "t5_hold");
        rst = 1'b1;
        @(negedge clk);
        check("t5_s_req", s_req, 0);
        check("t5_m_ack", m_ack, 0);
        check("t5_busy", busy, 0);
        check("t5_err", err, 0);
        check("t5_grant_id", grant_id, 0);
        rst  = 1'b0;
        hold = 1'b0;
        mdat[0] = 8'h0F; mdat[2] = 8'hF0;
        expect_grant(0, 8'h0F); expect_grant(2, 8'hF0);
        pend[0] = 1; pend[2] = 1;
        wait_for(4, "t5_done");

        // Granted master's data churns every cycle during REQ/HOLD
        hold     = 1'b1;
        scramble = 1'b1;
        mdat[0]  = 8'h3C;
        expect_grant(0, 8'h3C);
        pend[0] = 1;
        wait_for(3, "t6_m_ack");
        for (int k = 0; k < 3; k++) begin
            check("t6_s_data_held", s_data, 8'h3C);
            @(negedge clk);
        end
        hold = 1'b0;
        wait_for(4, "t6_done");
        scramble = 1'b0;

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
